disp_isq_writer: RTL and testbench
==================================

Name: disp_isq_writer

Overview:
- Dispatch-side producer for the issue queue write port.
- Takes one renamed micro-op per cycle from rename plus the ROB-allocated instr_id, and packs the 248-bit issue-queue word.
- Computes rs1/rs2 sleep bits from an internal physical-register busy table.
- Drives the valid/ready write handshake through a 2-entry skid buffer, so rename never sees a combinational path from the issue queue ready.

Parameters:
- DATA_WIDTH, 248, packed issue-queue word width.
- PREG_NUM, 64, number of physical registers (busy-table depth).
- PREG_W, 6, physical register index width.
- ID_W, 7, instr_id width (bit 6 = wrap bit).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- rn_valid  in  1  rename has a uop.
- rn_ready  out  1  writer accepts the uop.
- rn_uop  in  241  uop fields packed exactly as issue-queue bits [240:0] (pc down to ls_size).
- rob2disp_instr_id  in  ID_W  ROB id of the current uop.
- disp2isq_wr_valid  out  1  to issue queue isq_in_wr_valid.
- isq2disp_wr_ready  in  1  from issue queue isq_out_wr_ready.
- disp2isq_wrdata  out  DATA_WIDTH  {instr_id, rn_uop}.
- disp2isq_rs1_sleepbit  out  1  rs1 operand not yet produced.
- disp2isq_rs2_sleepbit  out  1  rs2 operand not yet produced.
- wb_valid  in  1  writeback of a preg this cycle.
- wb_prd  in  PREG_W  written-back preg.
- walk_clr_valid  in  1  rollback walk frees a preg's busy bit.
- walk_clr_prd  in  PREG_W  preg to clear.
- flush_valid  in  1  drop all buffered uops.
- is_rollingback  in  1  recovery in progress.
- is_walking  in  1  walk in progress.

Behaviour:
- Reset (reset_n=0 at a clock edge): buffer EMPTY, all busy bits 0, disp2isq_wr_valid=0, sleep outputs 0, disp2isq_wrdata=0. rn_ready=0 during reset.
- Buffer states:
  - EMPTY→ONE on an accept.
  - ONE→TWO on an accept without issue-queue fire.
  - ONE→EMPTY on fire without accept.
  - TWO→ONE on fire.
  - ONE stays ONE on simultaneous accept and fire.
  - Head is the oldest entry. A TWO→ONE fire moves the skid entry to the head.
- rn_ready = (state != TWO) && !flush_valid && !is_rollingback && !is_walking. This is a registered-state function; it has no dependence on isq2disp_wr_ready.
- Accept = rn_valid && rn_ready. It captures {rob2disp_instr_id, rn_uop} and the sleep bits.
- Fire = disp2isq_wr_valid && isq2disp_wr_ready; the head leaves on fire. disp2isq_wr_valid = (state != EMPTY) && !flush_valid.
- Sleep bit at accept:
  - Field offsets: src_is_reg, prs1 [116:111], prs2 [110:105], src1_is_reg [104], src2_is_reg [103], prd [129:124], need_to_wb [117].
  - rsN_sleep = srcN_is_reg && prsN != 0 && busy[prsN] && !(wb_valid && wb_prd == prsN).
- While a uop is buffered, wb_valid matching its prsN clears its stored sleep bit in the same edge. Sleep outputs come from the head entry.
- Busy table:
  - On accept with need_to_wb=1 and prd != 0: busy[prd] <= 1.
  - wb_valid: busy[wb_prd] <= 0. walk_clr_valid: busy[walk_clr_prd] <= 0.
  - If set and clear hit the same index in one cycle, set wins; the new producer is younger.
  - busy[0] is always 0.
- Back-to-back dependency: a uop accepted the cycle after its producer sees busy=1, so it sleeps. Producer-to-consumer in the same cycle cannot occur (one uop per cycle).
- flush_valid: next state EMPTY, no fire that cycle. The busy table is untouched; flushed producers are cleared via walk_clr_*.
- Reset mid-operation: state and busy table return to reset values regardless of handshakes.

Optional Feature:
- Macro: DISP_PERF_CNT_EN.
- When defined, adds three 32-bit saturating counters, readable via outputs perf_isq_full_cycles, perf_sleep_rs_dispatched, and perf_flush_drops:
  - cycles with valid && !isq2disp_wr_ready;
  - fired uops with any sleep bit set;
  - buffered uops dropped by flush.
- When undefined, no counters and no such ports.

Decomposition:
- Shared package/header: ISQ field offsets (ID, PRD, NEED_TO_WB, PRS1, PRS2, SRC1/2_IS_REG), DATA_WIDTH, PREG_RANGE, INSTR_ID_WIDTH.
- Sub-module preg_busy_table: PREG_NUM x 1 bit, one set port, two clear ports, two combinational read ports with wb bypass.

Test Plan:
- Single uop, prs1=5 not busy, isq ready → disp2isq_wr_valid one cycle after accept, wrdata[247:241]=id, both sleep bits 0.
- Uop A prd=9 need_to_wb=1, then uop B prs2=9 → B rs2_sleepbit=1. Repeat with wb_valid, wb_prd=9 in B's accept cycle → rs2_sleepbit=0.
- isq2disp_wr_ready held 0, three uops offered → two accepted, rn_ready=0 in the TWO state. Release ready → in-order delivery, no loss or duplication.
- Buffered uop sleeping on prs1=12, then wb_prd=12 → the following cycle disp2isq_rs1_sleepbit=0 with the same wrdata.
- flush_valid while in TWO → next cycle EMPTY, valid=0, no fire in the flush cycle; is_walking=1 holds rn_ready=0.
- busy[7]=1, walk_clr_prd=7 and accept with prd=7 in the same cycle → busy[7] remains 1. prd=0 with need_to_wb → busy[0] stays 0.

Source files
------------

// File: rtl/disp_isq_writer_pkg.sv
// Shared issue-queue word layout, widths and helpers for the dispatch-side issue-queue writer.
package disp_isq_writer_pkg;

    localparam int unsigned DATA_WIDTH     = 248;
    localparam int unsigned UOP_W          = 241;
    localparam int unsigned PREG_NUM       = 64;
    localparam int unsigned PREG_RANGE     = PREG_NUM;
    localparam int unsigned PREG_W         = 6;
    localparam int unsigned INSTR_ID_WIDTH = 7;
    localparam int unsigned PERF_W         = 32;

    // Bit offsets inside the packed issue-queue word
    localparam int unsigned ID_LSB          = 241;
    localparam int unsigned PRD_LSB         = 124;
    localparam int unsigned NEED_TO_WB_BIT  = 117;
    localparam int unsigned PRS1_LSB        = 111;
    localparam int unsigned PRS2_LSB        = 105;
    localparam int unsigned SRC1_IS_REG_BIT = 104;
    localparam int unsigned SRC2_IS_REG_BIT = 103;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  rs1_sleep;
        logic                  rs2_sleep;
    } isq_entry_t;

    function automatic logic [PREG_W-1:0] uop_prs1(input logic [UOP_W-1:0] uop);
        return uop[PRS1_LSB +: PREG_W];
    endfunction

    function automatic logic [PREG_W-1:0] uop_prs2(input logic [UOP_W-1:0] uop);
        return uop[PRS2_LSB +: PREG_W];
    endfunction

    function automatic logic [PREG_W-1:0] uop_prd(input logic [UOP_W-1:0] uop);
        return uop[PRD_LSB +: PREG_W];
    endfunction

    // A writeback of a buffered entry's source operand wakes that operand
    function automatic isq_entry_t wake_entry(input isq_entry_t e, input logic wb_valid,
                                              input logic [PREG_W-1:0] wb_prd);
        isq_entry_t r;
        r = e;
        if (wb_valid && (uop_prs1(e.data[UOP_W-1:0]) == wb_prd)) r.rs1_sleep = 1'b0;
        if (wb_valid && (uop_prs2(e.data[UOP_W-1:0]) == wb_prd)) r.rs2_sleep = 1'b0;
        return r;
    endfunction

    function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] cnt, input logic [1:0] inc);
        logic [PERF_W:0] sum;
        sum = (PERF_W+1)'(cnt) + (PERF_W+1)'(inc);
        return sum[PERF_W] ? {PERF_W{1'b1}} : sum[PERF_W-1:0];
    endfunction

endpackage

// File: rtl/disp_isq_writer_preg_busy_table.sv
// Physical-register busy table: one set port, two clear ports, two reads with writeback bypass.
module disp_isq_writer_preg_busy_table
    import disp_isq_writer_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              set_valid,
    input  logic [PREG_W-1:0] set_prd,
    input  logic              clr0_valid,
    input  logic [PREG_W-1:0] clr0_prd,
    input  logic              clr1_valid,
    input  logic [PREG_W-1:0] clr1_prd,
    input  logic [PREG_W-1:0] rd0_prs,
    input  logic [PREG_W-1:0] rd1_prs,
    output logic              rd0_busy,
    output logic              rd1_busy
);

    logic [PREG_RANGE-1:0] busy;
    logic [PREG_RANGE-1:0] busy_next;

    // Set is applied after the clears: the new producer is younger than any freed one
    always_comb begin
        busy_next = busy;
        if (clr0_valid) busy_next[clr0_prd] = 1'b0;
        if (clr1_valid) busy_next[clr1_prd] = 1'b0;
        if (set_valid)  busy_next[set_prd]  = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rd0_busy = busy[rd0_prs] && !(clr0_valid && (clr0_prd == rd0_prs));
    assign rd1_busy = busy[rd1_prs] && !(clr0_valid && (clr0_prd == rd1_prs));

endmodule

// File: rtl/disp_isq_writer.sv
// Dispatch-side issue-queue writer: packs renamed uops, computes sleep bits, 2-entry skid buffer.
// Define DISP_PERF_CNT_EN to add saturating performance counters.
module disp_isq_writer
    import disp_isq_writer_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rn_valid,
    output logic                      rn_ready,
    input  logic [UOP_W-1:0]          rn_uop,
    input  logic [INSTR_ID_WIDTH-1:0] rob2disp_instr_id,
    output logic                      disp2isq_wr_valid,
    input  logic                      isq2disp_wr_ready,
    output logic [DATA_WIDTH-1:0]     disp2isq_wrdata,
    output logic                      disp2isq_rs1_sleepbit,
    output logic                      disp2isq_rs2_sleepbit,
    input  logic                      wb_valid,
    input  logic [PREG_W-1:0]         wb_prd,
    input  logic                      walk_clr_valid,
    input  logic [PREG_W-1:0]         walk_clr_prd,
    input  logic                      flush_valid,
    input  logic                      is_rollingback,
`ifdef DISP_PERF_CNT_EN
    output logic [PERF_W-1:0]         perf_isq_full_cycles,
    output logic [PERF_W-1:0]         perf_sleep_rs_dispatched,
    output logic [PERF_W-1:0]         perf_flush_drops,
`endif
    input  logic                      is_walking
);

    buf_state_t state;
    isq_entry_t head;
    isq_entry_t skid;
    isq_entry_t head_woken;
    isq_entry_t skid_woken;
    isq_entry_t incoming;
    logic       accept;
    logic       fire;
    logic       rs1_busy;
    logic       rs2_busy;
    logic       busy_set;

    // Ready depends only on registered state and recovery inputs, never on the issue-queue ready
    assign rn_ready          = reset_n && (state != BUF_TWO) && !flush_valid
                               && !is_rollingback && !is_walking;
    assign disp2isq_wr_valid = reset_n && (state != BUF_EMPTY) && !flush_valid;
    assign accept            = rn_valid && rn_ready;
    assign fire              = disp2isq_wr_valid && isq2disp_wr_ready;

    assign busy_set = accept && rn_uop[NEED_TO_WB_BIT] && (uop_prd(rn_uop) != '0);

    disp_isq_writer_preg_busy_table u_busy (
        .clock      (clock),
        .reset_n    (reset_n),
        .set_valid  (busy_set),
        .set_prd    (uop_prd(rn_uop)),
        .clr0_valid (wb_valid),
        .clr0_prd   (wb_prd),
        .clr1_valid (walk_clr_valid),
        .clr1_prd   (walk_clr_prd),
        .rd0_prs    (uop_prs1(rn_uop)),
        .rd1_prs    (uop_prs2(rn_uop)),
        .rd0_busy   (rs1_busy),
        .rd1_busy   (rs2_busy)
    );

    always_comb begin
        incoming                                  = '0;
        incoming.data[UOP_W-1:0]                  = rn_uop;
        incoming.data[ID_LSB +: INSTR_ID_WIDTH]   = rob2disp_instr_id;
        incoming.rs1_sleep                        = rn_uop[SRC1_IS_REG_BIT] && rs1_busy;
        incoming.rs2_sleep                        = rn_uop[SRC2_IS_REG_BIT] && rs2_busy;
    end

    assign head_woken = wake_entry(head, wb_valid, wb_prd);
    assign skid_woken = wake_entry(skid, wb_valid, wb_prd);

    // Skid buffer: head is the oldest entry, skid holds the second
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= BUF_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            head <= head_woken;
            skid <= skid_woken;
            if (flush_valid) begin
                state <= BUF_EMPTY;
            end else begin
                case (state)
                    BUF_EMPTY: begin
                        if (accept) begin
                            head  <= incoming;
                            state <= BUF_ONE;
                        end
                    end
                    BUF_ONE: begin
                        if (accept && fire) begin
                            head <= incoming;
                        end else if (accept) begin
                            skid  <= incoming;
                            state <= BUF_TWO;
                        end else if (fire) begin
                            state <= BUF_EMPTY;
                        end
                    end
                    BUF_TWO: begin
                        if (fire) begin
                            head  <= skid_woken;
                            state <= BUF_ONE;
                        end
                    end
                    default: state <= BUF_EMPTY;
                endcase
            end
        end
    end

    assign disp2isq_wrdata       = head.data;
    assign disp2isq_rs1_sleepbit = head.rs1_sleep;
    assign disp2isq_rs2_sleepbit = head.rs2_sleep;

`ifdef DISP_PERF_CNT_EN
    logic [1:0] buffered;

    assign buffered = (state == BUF_TWO) ? 2'd2 : ((state == BUF_ONE) ? 2'd1 : 2'd0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_isq_full_cycles     <= '0;
            perf_sleep_rs_dispatched <= '0;
            perf_flush_drops         <= '0;
        end else begin
            if (disp2isq_wr_valid && !isq2disp_wr_ready)
                perf_isq_full_cycles <= sat_add(perf_isq_full_cycles, 2'd1);
            if (fire && (head.rs1_sleep || head.rs2_sleep))
                perf_sleep_rs_dispatched <= sat_add(perf_sleep_rs_dispatched, 2'd1);
            if (flush_valid)
                perf_flush_drops <= sat_add(perf_flush_drops, buffered);
        end
    end
`endif

endmodule

// File: tb/tb_disp_isq_writer.sv
// Bench for disp_isq_writer: directed scenarios plus random traffic against a queue-based model.
module tb_disp_isq_writer;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         rn_valid;
    logic         rn_ready;
    logic [240:0] rn_uop;
    logic [6:0]   rob2disp_instr_id;
    logic         disp2isq_wr_valid;
    logic         isq2disp_wr_ready;
    logic [247:0] disp2isq_wrdata;
    logic         disp2isq_rs1_sleepbit;
    logic         disp2isq_rs2_sleepbit;
    logic         wb_valid;
    logic [5:0]   wb_prd;
    logic         walk_clr_valid;
    logic [5:0]   walk_clr_prd;
    logic         flush_valid;
    logic         is_rollingback;
    logic         is_walking;

    typedef struct {
        logic [247:0] data;
        logic         s1;
        logic         s2;
        logic [5:0]   p1;
        logic [5:0]   p2;
    } ent_t;

    ent_t        q[$];
    logic [63:0] bm;
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clock = ~clock;

    disp_isq_writer dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .rn_valid              (rn_valid),
        .rn_ready              (rn_ready),
        .rn_uop                (rn_uop),
        .rob2disp_instr_id     (rob2disp_instr_id),
        .disp2isq_wr_valid     (disp2isq_wr_valid),
        .isq2disp_wr_ready     (isq2disp_wr_ready),
        .disp2isq_wrdata       (disp2isq_wrdata),
        .disp2isq_rs1_sleepbit (disp2isq_rs1_sleepbit),
        .disp2isq_rs2_sleepbit (disp2isq_rs2_sleepbit),
        .wb_valid              (wb_valid),
        .wb_prd                (wb_prd),
        .walk_clr_valid        (walk_clr_valid),
        .walk_clr_prd          (walk_clr_prd),
        .flush_valid           (flush_valid),
        .is_rollingback        (is_rollingback),
        .is_walking            (is_walking)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [240:0] mk_uop(input logic [5:0] p1, input logic [5:0] p2,
                                            input logic [5:0] pd, input logic s1,
                                            input logic s2, input logic nwb);
        logic [255:0] r;
        logic [240:0] u;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        u = r[240:0];
        u[116:111] = p1;
        u[110:105] = p2;
        u[129:124] = pd;
        u[104]     = s1;
        u[103]     = s2;
        u[117]     = nwb;
        return u;
    endfunction

    task automatic idle();
        rn_valid          = 1'b0;
        rn_uop            = '0;
        rob2disp_instr_id = '0;
        isq2disp_wr_ready = 1'b1;
        wb_valid          = 1'b0;
        wb_prd            = '0;
        walk_clr_valid    = 1'b0;
        walk_clr_prd      = '0;
        flush_valid       = 1'b0;
        is_rollingback    = 1'b0;
        is_walking        = 1'b0;
    endtask

    // Check outputs against the model, advance the model by one clock, return at the next negedge
    task automatic step();
        ent_t e;
        ent_t t;
        logic exp_ready;
        logic exp_valid;
        logic acc;
        logic fr;
        #1;
        exp_ready = (q.size() < 2) && !flush_valid && !is_rollingback && !is_walking;
        exp_valid = (q.size() > 0) && !flush_valid;
        chk("rn_ready", 256'(rn_ready), 256'(exp_ready));
        chk("wr_valid", 256'(disp2isq_wr_valid), 256'(exp_valid));
        if (exp_valid) begin
            chk("wrdata", 256'(disp2isq_wrdata), 256'(q[0].data));
            chk("rs1_sleep", 256'(disp2isq_rs1_sleepbit), 256'(q[0].s1));
            chk("rs2_sleep", 256'(disp2isq_rs2_sleepbit), 256'(q[0].s2));
        end
        acc    = rn_valid && exp_ready;
        fr     = exp_valid && isq2disp_wr_ready;
        e.data = {rob2disp_instr_id, rn_uop};
        e.p1   = rn_uop[116:111];
        e.p2   = rn_uop[110:105];
        e.s1   = rn_uop[104] && (e.p1 != 0) && bm[e.p1] && !(wb_valid && wb_prd == e.p1);
        e.s2   = rn_uop[103] && (e.p2 != 0) && bm[e.p2] && !(wb_valid && wb_prd == e.p2);
        if (flush_valid) begin
            q.delete();
        end else begin
            if (fr) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) begin
                t = q[i];
                if (wb_valid && t.p1 == wb_prd) t.s1 = 1'b0;
                if (wb_valid && t.p2 == wb_prd) t.s2 = 1'b0;
                q[i] = t;
            end
            if (acc) q.push_back(e);
        end
        if (wb_valid) bm[wb_prd] = 1'b0;
        if (walk_clr_valid) bm[walk_clr_prd] = 1'b0;
        if (acc && rn_uop[117] && rn_uop[129:124] != 0) bm[rn_uop[129:124]] = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) begin
            #1;
            chk("reset_rn_ready", 256'(rn_ready), 256'(1'b0));
            @(negedge clock);
        end
        reset_n = 1'b1;
        q.delete();
        bm = '0;
        #1;
        chk("reset_wr_valid", 256'(disp2isq_wr_valid), 256'(1'b0));
        chk("reset_wrdata", 256'(disp2isq_wrdata), 256'(0));
        chk("reset_rs1", 256'(disp2isq_rs1_sleepbit), 256'(1'b0));
        chk("reset_rs2", 256'(disp2isq_rs2_sleepbit), 256'(1'b0));
        chk("reset_rn_ready_after", 256'(rn_ready), 256'(1'b1));
        @(negedge clock);
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        bm      = '0;
        @(negedge clock);
        do_reset();

        // Single uop, prs1=5 not busy
        rn_valid = 1'b1; rn_uop = mk_uop(6'd5, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        rob2disp_instr_id = 7'h2a;
        step();
        idle();
        chk("single_valid", 256'(disp2isq_wr_valid), 256'(1'b1));
        chk("single_id", 256'(disp2isq_wrdata[247:241]), 256'(7'h2a));
        chk("single_rs1", 256'(disp2isq_rs1_sleepbit), 256'(1'b0));
        step();

        // Back-to-back dependency sleeps, then same-cycle writeback bypass
        rn_valid = 1'b1; rn_uop = mk_uop(6'd0, 6'd0, 6'd9, 1'b0, 1'b0, 1'b1); rob2disp_instr_id = 7'd1;
        step();
        rn_uop = mk_uop(6'd0, 6'd9, 6'd0, 1'b0, 1'b1, 1'b0); rob2disp_instr_id = 7'd2;
        step();
        idle();
        chk("b2b_rs2_sleep", 256'(disp2isq_rs2_sleepbit), 256'(1'b1));
        wb_valid = 1'b1; wb_prd = 6'd9;
        step();
        idle();
        rn_valid = 1'b1; rn_uop = mk_uop(6'd0, 6'd0, 6'd9, 1'b0, 1'b0, 1'b1); rob2disp_instr_id = 7'd3;
        step();
        rn_uop = mk_uop(6'd0, 6'd9, 6'd0, 1'b0, 1'b1, 1'b0); rob2disp_instr_id = 7'd4;
        wb_valid = 1'b1; wb_prd = 6'd9;
        step();
        idle();
        chk("bypass_rs2_sleep", 256'(disp2isq_rs2_sleepbit), 256'(1'b0));
        step();

        // Issue queue stalled: two accepted, third held off
        isq2disp_wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rn_valid = 1'b1; rn_uop = mk_uop(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
            rob2disp_instr_id = 7'(10 + k);
            step();
            if (k == 1) chk("two_rn_ready", 256'(rn_ready), 256'(1'b0));
        end
        chk("inorder_head_id", 256'(disp2isq_wrdata[247:241]), 256'(7'd10));
        idle();
        repeat (3) step();

        // Buffered sleeper woken by writeback
        rn_valid = 1'b1; rn_uop = mk_uop(6'd0, 6'd0, 6'd12, 1'b0, 1'b0, 1'b1); rob2disp_instr_id = 7'd20;
        step();
        rn_uop = mk_uop(6'd12, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0); rob2disp_instr_id = 7'd21;
        step();
        idle(); isq2disp_wr_ready = 1'b0;
        chk("wake_pre_rs1", 256'(disp2isq_rs1_sleepbit), 256'(1'b1));
        wb_valid = 1'b1; wb_prd = 6'd12;
        step();
        idle(); isq2disp_wr_ready = 1'b0;
        chk("wake_post_rs1", 256'(disp2isq_rs1_sleepbit), 256'(1'b0));
        chk("wake_post_id", 256'(disp2isq_wrdata[247:241]), 256'(7'd21));
        isq2disp_wr_ready = 1'b1;
        step();

        // Flush while full, then walk blocks rename
        isq2disp_wr_ready = 1'b0;
        rn_valid = 1'b1; rn_uop = mk_uop(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0); rob2disp_instr_id = 7'd30;
        step();
        rob2disp_instr_id = 7'd31;
        step();
        flush_valid = 1'b1; isq2disp_wr_ready = 1'b1;
        step();
        idle();
        chk("post_flush_valid", 256'(disp2isq_wr_valid), 256'(1'b0));
        is_walking = 1'b1; rn_valid = 1'b1; rob2disp_instr_id = 7'd32;
        rn_uop = mk_uop(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("walk_rn_ready", 256'(rn_ready), 256'(1'b0));
        idle();
        step();

        // Set beats walk clear on the same preg; preg 0 never becomes busy
        rn_valid = 1'b1; rn_uop = mk_uop(6'd0, 6'd0, 6'd7, 1'b0, 1'b0, 1'b1); rob2disp_instr_id = 7'd40;
        step();
        rn_uop = mk_uop(6'd0, 6'd0, 6'd7, 1'b0, 1'b0, 1'b1); rob2disp_instr_id = 7'd41;
        walk_clr_valid = 1'b1; walk_clr_prd = 6'd7;
        step();
        walk_clr_valid = 1'b0;
        rn_uop = mk_uop(6'd7, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0); rob2disp_instr_id = 7'd42;
        step();
        chk("busy7_set_wins", 256'(disp2isq_rs1_sleepbit), 256'(1'b1));
        rn_uop = mk_uop(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1); rob2disp_instr_id = 7'd43;
        step();
        rn_uop = mk_uop(6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0); rob2disp_instr_id = 7'd44;
        step();
        idle();
        step();
        chk("busy0_rs1", 256'(disp2isq_rs1_sleepbit), 256'(1'b0));
        wb_valid = 1'b1; wb_prd = 6'd7;
        step();
        idle();
        step();

        // Random traffic with a mid-run reset
        for (int n = 0; n < 1500; n++) begin
            rn_valid          = ($urandom_range(0, 9) < 7);
            rn_uop            = mk_uop(6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                                       6'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                                       1'($urandom));
            rob2disp_instr_id = 7'($urandom);
            isq2disp_wr_ready = ($urandom_range(0, 9) < 6);
            wb_valid          = ($urandom_range(0, 9) < 4);
            wb_prd            = 6'($urandom_range(0, 15));
            walk_clr_valid    = ($urandom_range(0, 9) == 0);
            walk_clr_prd      = 6'($urandom_range(0, 15));
            flush_valid       = ($urandom_range(0, 29) == 0);
            is_rollingback    = ($urandom_range(0, 19) == 0);
            is_walking        = ($urandom_range(0, 19) == 0);
            step();
            if (n == 700) do_reset();
        end
        idle();
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
